// File: rtl/fft8_bitrev_loader.sv
// Input stage of the 8-point FFT/IFFT datapath. It buffers one natural-order frame of complex
// fp16 samples and replays it in bit-reversed order, conjugating the samples in IFFT mode.
module fft8_bitrev_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        ifft_mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_re,
  input  logic [15:0] in_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_re,
  output logic [15:0] out_im,
  output logic [2:0]  out_index,
  output logic        out_last,
  output logic        frame_ifft
);

  localparam int unsigned W     = 16;
  localparam int unsigned N     = 8;
  localparam int unsigned LOG2N = 3;

  typedef enum logic {StFill, StDrain} state_e;

  state_e             state_q, state_d;
  logic [LOG2N-1:0]   wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0]   rd_cnt_q, rd_cnt_d;
  logic               frame_ifft_q, frame_ifft_d;
  logic [2*W-1:0]     mem_q [N];
  logic               mem_we;
  logic [LOG2N-1:0]   rd_addr;
  logic [2*W-1:0]     rd_word;
  logic [W-1:0]       rd_im;

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    frame_ifft_d = frame_ifft_q;
    mem_we       = 1'b0;
    // clear overrides any handshake in the same cycle
    if (clear) begin
      state_d  = StFill;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (in_valid) begin
            mem_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + 3'd1;
            if (wr_cnt_q == 3'd0) frame_ifft_d = ifft_mode;
            if (wr_cnt_q == 3'd7) state_d = StDrain;
          end
        end
        StDrain: begin
          if (out_ready) begin
            rd_cnt_d = rd_cnt_q + 3'd1;
            if (rd_cnt_q == 3'd7) state_d = StFill;
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFill;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      frame_ifft_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      frame_ifft_q <= frame_ifft_d;
    end
  end

  // Sample storage needs no reset: nothing is read until a full frame has been written.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_cnt_q] <= {in_re, in_im};
  end

  assign rd_addr = {rd_cnt_q[0], rd_cnt_q[1], rd_cnt_q[2]};
  assign rd_word = mem_q[rd_addr];
  assign rd_im   = rd_word[W-1:0];

  always_comb begin
    in_ready   = (state_q == StFill);
    out_valid  = (state_q == StDrain);
    out_re     = '0;
    out_im     = '0;
    out_index  = '0;
    out_last   = 1'b0;
    frame_ifft = frame_ifft_q;
    if (state_q == StDrain) begin
      out_re    = rd_word[2*W-1:W];
      // Signed zeros collapse to +0: downstream only special-cases the all-zero word.
      if (rd_im[W-2:0] != '0) out_im = {rd_im[W-1] ^ frame_ifft_q, rd_im[W-2:0]};
      out_index = rd_cnt_q;
      out_last  = (rd_cnt_q == 3'd7);
    end
  end

endmodule

// File: tb/tb_fft8_bitrev_loader.sv
// Directed bench for fft8_bitrev_loader: frame order, IFFT conjugation, backpressure,
// input gaps, clear collisions and asynchronous reset mid-drain.
module tb_fft8_bitrev_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        ifft_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_re = 16'h0;
  logic [15:0] in_im = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic [2:0]  out_index;
  logic        out_last;
  logic        frame_ifft;

  int checks = 0;
  int errors = 0;
  int br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [15:0] fre[8];
  logic [15:0] fim[8];

  fft8_bitrev_loader dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .ifft_mode  (ifft_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_index  (out_index),
    .out_last   (out_last),
    .frame_ifft (frame_ifft)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic mode,
                      input logic clr);
    in_valid  = 1'b1;
    in_re     = re;
    in_im     = im;
    ifft_mode = mode;
    clear     = clr;
    tick();
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic set_frame(input logic [15:0] re0, input logic [15:0] im0);
    for (int k = 0; k < 8; k++) begin
      fre[k] = re0 + 16'(k);
      fim[k] = im0 + 16'(k);
    end
  endtask

  // Mode is driven as mode_first on sample 0 and mode_rest on all later samples.
  task automatic send_frame(input logic mode_first, input logic mode_rest);
    for (int k = 0; k < 8; k++) begin
      send(fre[k], fim[k], (k == 0) ? mode_first : mode_rest, 1'b0);
      if (k < 7) begin
        chk("fill_out_valid", 32'(out_valid), 32'(1'b0));
        chk("fill_in_ready", 32'(in_ready), 32'(1'b1));
      end
    end
    chk("turnaround_out_valid", 32'(out_valid), 32'(1'b1));
  endtask

  function automatic logic [15:0] model_im(input logic [15:0] im, input logic conj);
    if (im[14:0] == 15'h0) return 16'h0000;
    return conj ? {~im[15], im[14:0]} : im;
  endfunction

  task automatic drain(input logic conj);
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(out_valid), 32'(1'b1));
      chk("drain_re", 32'(out_re), 32'(fre[br[i]]));
      chk("drain_im", 32'(out_im), 32'(model_im(fim[br[i]], conj)));
      chk("drain_index", 32'(out_index), 32'(i));
      chk("drain_last", 32'(out_last), 32'(i == 7));
      chk("drain_in_ready", 32'(in_ready), 32'(1'b0));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chk("done_out_valid", 32'(out_valid), 32'(1'b0));
    chk("done_in_ready", 32'(in_ready), 32'(1'b1));
  endtask

  initial begin
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'(1'b1));
    chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("rst_out_last", 32'(out_last), 32'(1'b0));
    chk("rst_out_index", 32'(out_index), 32'(3'd0));
    chk("rst_out_re", 32'(out_re), 32'(16'h0000));
    chk("rst_out_im", 32'(out_im), 32'(16'h0000));
    chk("rst_frame_ifft", 32'(frame_ifft), 32'(1'b0));
    rst = 1'b0;
    tick();

    // FFT frame order
    set_frame(16'h3C00, 16'h4000);
    send_frame(1'b0, 1'b0);
    chk("fft_frame_ifft", 32'(frame_ifft), 32'(1'b0));
    drain(1'b0);

    // IFFT conjugation with signed zeros; mode toggled after first sample
    for (int k = 0; k < 8; k++) begin
      fre[k] = 16'h1000 + 16'(k);
      fim[k] = 16'h3C00;
    end
    fim[3] = 16'h8000;
    fim[5] = 16'h0000;
    send_frame(1'b1, 1'b0);
    chk("ifft_frame_ifft", 32'(frame_ifft), 32'(1'b1));
    chk("ifft_first_im", 32'(out_im), 32'(16'hBC00));
    drain(1'b1);

    // Backpressure at index 2; mode toggled the other way
    set_frame(16'h2000, 16'h5000);
    send_frame(1'b0, 1'b1);
    chk("bp_frame_ifft", 32'(frame_ifft), 32'(1'b0));
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        out_ready = 1'b0;
        repeat (5) begin
          tick();
          chk("bp_stall_valid", 32'(out_valid), 32'(1'b1));
          chk("bp_stall_re", 32'(out_re), 32'(16'h2002));
          chk("bp_stall_im", 32'(out_im), 32'(16'h5002));
          chk("bp_stall_index", 32'(out_index), 32'(3'd2));
          chk("bp_stall_in_ready", 32'(in_ready), 32'(1'b0));
        end
      end
      chk("bp_re", 32'(out_re), 32'(fre[br[i]]));
      chk("bp_index", 32'(out_index), 32'(i));
      chk("bp_last", 32'(out_last), 32'(i == 7));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chk("bp_done_valid", 32'(out_valid), 32'(1'b0));

    // Input gaps: only valid cycles are stored
    set_frame(16'h6000, 16'h6100);
    for (int c = 0; c < 16; c++) begin
      in_valid  = (c % 2 == 0);
      in_re     = (c % 2 == 0) ? fre[c / 2] : 16'hFFFF;
      in_im     = (c % 2 == 0) ? fim[c / 2] : 16'hFFFF;
      ifft_mode = 1'b0;
      tick();
      if (c < 14) chk("gap_out_valid", 32'(out_valid), 32'(1'b0));
    end
    in_valid = 1'b0;
    chk("gap_full_valid", 32'(out_valid), 32'(1'b1));
    drain(1'b0);

    // clear collides with the 6th input handshake
    set_frame(16'h7000, 16'h7100);
    for (int k = 0; k < 5; k++) send(fre[k], fim[k], k == 0, 1'b0);
    chk("clr_pre_ifft", 32'(frame_ifft), 32'(1'b1));
    send(fre[5], fim[5], 1'b0, 1'b1);
    chk("clr_in_ready", 32'(in_ready), 32'(1'b1));
    chk("clr_out_valid", 32'(out_valid), 32'(1'b0));
    chk("clr_keeps_ifft", 32'(frame_ifft), 32'(1'b1));
    set_frame(16'h7200, 16'h7300);
    send_frame(1'b0, 1'b0);
    chk("clr_new_ifft", 32'(frame_ifft), 32'(1'b0));
    drain(1'b0);

    // clear during drain at index 4
    set_frame(16'h7400, 16'h7500);
    send_frame(1'b0, 1'b0);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("clrd_index", 32'(out_index), 32'(3'd4));
    chk("clrd_last", 32'(out_last), 32'(1'b0));
    clear = 1'b1;
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    chk("clrd_out_valid", 32'(out_valid), 32'(1'b0));
    chk("clrd_in_ready", 32'(in_ready), 32'(1'b1));
    chk("clrd_out_last", 32'(out_last), 32'(1'b0));
    set_frame(16'h7600, 16'h7700);
    send_frame(1'b0, 1'b0);
    drain(1'b0);

    // Async reset mid-drain, between clock edges
    set_frame(16'h4400, 16'h4800);
    send_frame(1'b1, 1'b1);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("arst_in_ready", 32'(in_ready), 32'(1'b1));
    chk("arst_out_re", 32'(out_re), 32'(16'h0000));
    chk("arst_out_im", 32'(out_im), 32'(16'h0000));
    chk("arst_out_index", 32'(out_index), 32'(3'd0));
    chk("arst_out_last", 32'(out_last), 32'(1'b0));
    chk("arst_frame_ifft", 32'(frame_ifft), 32'(1'b0));
    #1 rst = 1'b0;
    tick();
    set_frame(16'h5400, 16'h5800);
    send_frame(1'b0, 1'b0);
    drain(1'b0);
    set_frame(16'h5500, 16'hC900);
    send_frame(1'b1, 1'b0);
    drain(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
